// File: rtl/comp_serial_ctrl.sv
// Bit-serial magnitude comparator: one comp_cell walks the operands LSB first,
// feeding each cell result back as the next cascade input.

module comp_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_eq,
  input  logic i_lt,
  input  logic i_gt,
  output logic o_eq,
  output logic o_lt,
  output logic o_gt
);

  logic w_same;

  // A differing bit overrides whatever the less significant bits decided.
  assign w_same = ~(i_a ^ i_b);
  assign o_eq   = w_same & i_eq;
  assign o_lt   = (~i_a & i_b) | (w_same & i_lt);
  assign o_gt   = (i_a & ~i_b) | (w_same & i_gt);

endmodule

module comp_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  output logic             busy
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [IDX_W-1:0] r_idx;
  logic             r_acc_eq;
  logic             r_acc_lt;
  logic             r_acc_gt;
  logic             r_eq;
  logic             r_lt;
  logic             r_gt;

  logic             w_last;
  logic             w_swap;
  logic             w_cell_a;
  logic             w_cell_b;
  logic             w_cell_eq;
  logic             w_cell_lt;
  logic             w_cell_gt;

  assign w_last = (r_idx == LAST_IDX);

  // Swapping the sign bits makes a set sign bit read as the smaller operand.
  assign w_swap   = w_last & r_signed;
  assign w_cell_a = w_swap ? r_b[r_idx] : r_a[r_idx];
  assign w_cell_b = w_swap ? r_a[r_idx] : r_b[r_idx];

  comp_cell u_cell (
    .i_a  (w_cell_a),
    .i_b  (w_cell_b),
    .i_eq (r_acc_eq),
    .i_lt (r_acc_lt),
    .i_gt (r_acc_gt),
    .o_eq (w_cell_eq),
    .o_lt (w_cell_lt),
    .o_gt (w_cell_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start_valid) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_idx    <= '0;
      r_acc_eq <= 1'b0;
      r_acc_lt <= 1'b0;
      r_acc_gt <= 1'b0;
      r_eq     <= 1'b0;
      r_lt     <= 1'b0;
      r_gt     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_signed <= signed_mode;
            r_idx    <= '0;
            r_acc_eq <= 1'b1;
            r_acc_lt <= 1'b0;
            r_acc_gt <= 1'b0;
          end
        end
        RUN: begin
          r_acc_eq <= w_cell_eq;
          r_acc_lt <= w_cell_lt;
          r_acc_gt <= w_cell_gt;
          if (w_last) begin
            r_eq <= w_cell_eq;
            r_lt <= w_cell_lt;
            r_gt <= w_cell_gt;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign start_ready = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign res_valid   = (r_state == DONE);
  assign eq          = r_eq;
  assign lt          = r_lt;
  assign gt          = r_gt;

endmodule

// File: tb/tb_comp_serial_ctrl.sv
// Directed bench for comp_serial_ctrl: hand-computed flags, exact latency,
// backpressure, ignored requests and asynchronous reset mid-operation.

module tb_comp_serial_ctrl;

  localparam int WIDTH = 8;
  localparam logic [2:0] F_EQ = 3'b100;
  localparam logic [2:0] F_LT = 3'b010;
  localparam logic [2:0] F_GT = 3'b001;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             res_valid;
  logic             res_ready;
  logic             eq;
  logic             lt;
  logic             gt;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  comp_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .eq          (eq),
    .lt          (lt),
    .gt          (gt),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one compare, scrambling inputs during RUN; optionally pulses start_valid at RUN cycle pulse_at.
  task automatic run_compare(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                             input logic sm, input logic [2:0] exp_flags, input int pulse_at);
    @(negedge clk);
    a = op_a;
    b = op_b;
    signed_mode = sm;
    start_valid = 1'b1;
    res_ready = 1'b0;
    check({tag, ":idle_ready"}, 32'(start_ready), 32'd1);
    @(posedge clk);
    for (int k = 0; k < WIDTH; k++) begin
      @(negedge clk);
      start_valid = (k == pulse_at);
      a = ~op_a ^ 8'(k);
      b = op_b + 8'(k + 1);
      signed_mode = ~sm;
      check({tag, ":run_valid"}, 32'(res_valid), 32'd0);
      check({tag, ":run_busy"}, 32'(busy), 32'd1);
      check({tag, ":run_ready"}, 32'(start_ready), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    start_valid = 1'b0;
    check({tag, ":done_valid"}, 32'(res_valid), 32'd1);
    check({tag, ":done_busy"}, 32'(busy), 32'd1);
    check({tag, ":done_ready"}, 32'(start_ready), 32'd0);
    check({tag, ":flags"}, 32'({eq, lt, gt}), 32'(exp_flags));
  endtask

  task automatic release_result(input string tag, input logic [2:0] exp_flags);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, ":rel_ready"}, 32'(start_ready), 32'd1);
    check({tag, ":rel_busy"}, 32'(busy), 32'd0);
    check({tag, ":rel_valid"}, 32'(res_valid), 32'd0);
    check({tag, ":rel_flags"}, 32'({eq, lt, gt}), 32'(exp_flags));
  endtask

  initial begin
    rst_n = 1'b0;
    start_valid = 1'b0;
    res_ready = 1'b0;
    a = '0;
    b = '0;
    signed_mode = 1'b0;
    #1;
    check("rst_ready", 32'(start_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_flags", 32'({eq, lt, gt}), 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    run_compare("u_eq_5a", 8'h5A, 8'h5A, 1'b0, F_EQ, -1);
    release_result("u_eq_5a", F_EQ);
    run_compare("u_lt_3c_c3", 8'h3C, 8'hC3, 1'b0, F_LT, -1);
    release_result("u_lt_3c_c3", F_LT);
    run_compare("u_gt_ff_00", 8'hFF, 8'h00, 1'b0, F_GT, -1);
    release_result("u_gt_ff_00", F_GT);
    run_compare("s_lt_80_7f", 8'h80, 8'h7F, 1'b1, F_LT, -1);
    release_result("s_lt_80_7f", F_LT);
    run_compare("u_gt_80_7f", 8'h80, 8'h7F, 1'b0, F_GT, -1);
    release_result("u_gt_80_7f", F_GT);
    run_compare("s_gt_ff_fe", 8'hFF, 8'hFE, 1'b1, F_GT, -1);
    release_result("s_gt_ff_fe", F_GT);
    run_compare("s_gt_01_ff", 8'h01, 8'hFF, 1'b1, F_GT, -1);
    release_result("s_gt_01_ff", F_GT);
    run_compare("s_eq_80_80", 8'h80, 8'h80, 1'b1, F_EQ, -1);
    release_result("s_eq_80_80", F_EQ);
    run_compare("u_lt_fe_ff", 8'hFE, 8'hFF, 1'b0, F_LT, -1);
    release_result("u_lt_fe_ff", F_LT);

    // Backpressure: result must hold while inputs wander.
    run_compare("bp_gt_81_7e", 8'h81, 8'h7E, 1'b0, F_GT, -1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a = 8'($urandom);
      b = 8'($urandom);
      signed_mode = 1'($urandom);
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_flags", 32'({eq, lt, gt}), 32'(F_GT));
      check("bp_ready", 32'(start_ready), 32'd0);
    end
    release_result("bp_gt_81_7e", F_GT);

    // Request pulsed during RUN is dropped and must not start another compare.
    run_compare("ign_lt_10_20", 8'h10, 8'h20, 1'b0, F_LT, 2);
    release_result("ign_lt_10_20", F_LT);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ign_idle_busy", 32'(busy), 32'd0);
      check("ign_idle_ready", 32'(start_ready), 32'd1);
    end

    // Asynchronous reset with idx=3 in RUN.
    @(negedge clk);
    a = 8'hAA;
    b = 8'h55;
    signed_mode = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
    for (int k = 0; k < 3; k++) @(posedge clk);
    #2;
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(start_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_flags", 32'({eq, lt, gt}), 32'd0);
    @(negedge clk);
    check("held_rst_valid", 32'(res_valid), 32'd0);
    rst_n = 1'b1;
    run_compare("post_rst_lt_01_02", 8'h01, 8'h02, 1'b0, F_LT, -1);
    release_result("post_rst_lt_01_02", F_LT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
